// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the MiniMIPS32 pipeline controller: exception codes,
// stall vector encodings, FSM state codes and the stall-merge helper.
package pipeline_ctrl_pkg;

  localparam int EXC_CODE_WIDTH = 5;

  localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'h10;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_SYSCALL = 5'h08;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET    = 5'h11;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FREEZE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  typedef struct packed {
    logic [1:0] state;
    logic       exc_accept;
  } ctrl_dbg_t;

  // Later stages hold everything upstream of them, so each encoding is a superset of the next.
  function automatic logic [5:0] merge_stall(input logic id, input logic ex, input logic mem);
    logic [5:0] res;
    res = STALL_NONE;
    if (mem)     res = STALL_MEM;
    else if (ex) res = STALL_EX;
    else if (id) res = STALL_ID;
    return res;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline stages and the controller. Level signals only:
// requests are sampled every cycle, outputs are valid every cycle (new_pc only while flush=1).
interface pipeline_ctrl_if import pipeline_ctrl_pkg::*; #(
  parameter int CNT_W = 32
);
  logic                      stallreq_id;
  logic                      stallreq_ex;
  logic                      stallreq_mem;
  logic [EXC_CODE_WIDTH-1:0] exc_code_i;
  logic [31:0]               cp0_epc_i;
  logic [5:0]                stall;
  logic                      flush;
  logic [31:0]               new_pc;
  logic                      stall_timeout;
  logic [CNT_W-1:0]          stall_cycles;
  ctrl_dbg_t                 dbg;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, exc_code_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cycles, dbg
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, exc_code_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, stall_cycles, dbg
  );
endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Saturating consecutive-stall watchdog with sticky timeout flag, plus a
// free-running (wrapping) stalled-cycle performance counter.
module pipeline_ctrl_stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             stall_i,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycles_o
);
  localparam int              WD_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  // Exception freeze/flush cycles are not hazards, so the watchdog only looks at RUN cycles.
  always_comb begin
    wd_d = wd_q;
    if (run_i) begin
      if (stall_i) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
      else         wd_d = '0;
    end
    timeout_d = timeout_q | (wd_d == WD_MAX);
    cycles_d  = cycles_q + CNT_W'(stall_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign timeout_o = timeout_q;
  assign cycles_o  = cycles_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception/ERET
// entry (accept -> FREEZE -> FLUSH) and hosts the stall watchdog.
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 32
) (
  input logic           cpu_clk_75M,
  input logic           cpu_rst_n,
  pipeline_ctrl_if.slave bus
);
  logic [1:0]  state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        flush_q, flush_d;
  logic        exc_accept;
  logic [5:0]  stall_run;
  logic [5:0]  stall_out;

  always_comb begin
    stall_run  = merge_stall(bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
    exc_accept = 1'b0;
    state_d    = state_q;
    new_pc_d   = new_pc_q;
    flush_d    = 1'b0;
    stall_out  = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        stall_out = stall_run;
        // A pending data-bus access must finish before the exception is taken.
        if ((bus.exc_code_i != EC_NONE) && !bus.stallreq_mem) begin
          exc_accept = 1'b1;
          stall_out  = STALL_ALL;
          state_d    = ST_FREEZE;
          new_pc_d   = (bus.exc_code_i == EC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
        end
      end
      ST_FREEZE: begin
        stall_out = STALL_ALL;
        state_d   = ST_FLUSH;
        flush_d   = 1'b1;
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // The RUN decode is combinational from the requests, so hold it quiet while in reset.
    if (!cpu_rst_n) stall_out = STALL_NONE;
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q  <= ST_RUN;
      new_pc_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
      flush_q  <= flush_d;
    end
  end

  pipeline_ctrl_stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk_i     (cpu_clk_75M),
    .rst_ni    (cpu_rst_n),
    .run_i     (state_q == ST_RUN),
    .stall_i   (|stall_out),
    .timeout_o (bus.stall_timeout),
    .cycles_o  (bus.stall_cycles)
  );

  assign bus.stall          = stall_out;
  assign bus.flush          = flush_q;
  assign bus.new_pc         = flush_q ? new_pc_q : 32'h0;
  assign bus.dbg.state      = state_q;
  assign bus.dbg.exc_accept = exc_accept;
endmodule
